// File: rtl/cache_defs.sv
// Shared definitions for the data cache: FSM states, default geometry and
// helpers that derive the address field widths from the geometry.
package cache_defs;

    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TAG_CHECK  = 3'd1,
        WRITE_BACK = 3'd2,
        ALLOCATE   = 3'd3,
        FILL_WAIT  = 3'd4
    } state_e;

    // Word offset within a line.
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Set index.
    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag is whatever sits above byte offset, word offset and index.
    function automatic int tag_w(input int num_sets, input int line_words);
        return ADDR_W - 2 - $clog2(num_sets) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache. The cache uses the
// slave modport; the CPU/memory side (or a testbench) uses master.
interface data_cache_if #(
    parameter int LINE_WORDS = 4
);
    logic                     is_input_valid;
    logic [31:0]              addr;
    logic                     mem_rw;
    logic [31:0]              din;
    logic                     is_ready;
    logic                     is_output_valid;
    logic [31:0]              dout;
    logic                     is_hit;

    logic                     mem_req;
    logic                     mem_req_write;
    logic [31:0]              mem_req_addr;
    logic [32*LINE_WORDS-1:0] mem_req_data;
    logic                     mem_req_ready;
    logic                     mem_resp_valid;
    logic [32*LINE_WORDS-1:0] mem_resp_data;

    logic [31:0]              hit_count;
    logic [31:0]              miss_count;

    modport slave (
        input  is_input_valid, addr, mem_rw, din,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output is_ready, is_output_valid, dout, is_hit,
        output mem_req, mem_req_write, mem_req_addr, mem_req_data,
        output hit_count, miss_count
    );

    modport master (
        output is_input_valid, addr, mem_rw, din,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  is_ready, is_output_valid, dout, is_hit,
        input  mem_req, mem_req_write, mem_req_addr, mem_req_data,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/data_cache_line_array.sv
// Line storage: valid/dirty/tag/data per set. One combinational read port,
// one word-write port (marks the line dirty) and one whole-line fill port
// (marks the line valid and clean). Only valid/dirty are reset.
module cache_line_array
    import cache_defs::*;
#(
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAG_W      = tag_w(DEF_NUM_SETS, DEF_LINE_WORDS)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [$clog2(NUM_SETS)-1:0]   rd_idx_i,
    output logic                          rd_valid_o,
    output logic                          rd_dirty_o,
    output logic [TAG_W-1:0]              rd_tag_o,
    output logic [WORD_W*LINE_WORDS-1:0]  rd_line_o,
    input  logic                          wr_en_i,
    input  logic [$clog2(NUM_SETS)-1:0]   wr_idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_off_i,
    input  logic [WORD_W-1:0]             wr_data_i,
    input  logic                          fill_en_i,
    input  logic [$clog2(NUM_SETS)-1:0]   fill_idx_i,
    input  logic [TAG_W-1:0]              fill_tag_i,
    input  logic [WORD_W*LINE_WORDS-1:0]  fill_line_i
);
    localparam int LINE_W = WORD_W * LINE_WORDS;

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    // Line state bits: cleared on reset, set clean by a fill, dirtied by a store.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_en_i) begin
                valid_q[fill_idx_i] <= 1'b1;
                dirty_q[fill_idx_i] <= 1'b0;
            end
            if (wr_en_i) begin
                dirty_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    // Tag and data payload; no reset needed since valid gates every use.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_line_i;
        end
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i*WORD_W +: WORD_W] <= wr_data_i;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. One request at a
// time: latch, tag check, optional victim write-back, line fill, replay.
module data_cache
    import cache_defs::*;
#(
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic      clk,
    input  logic      reset,
    data_cache_if.slave bus
);
    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(NUM_SETS);
    localparam int TAG_W  = tag_w(NUM_SETS, LINE_WORDS);
    localparam int LINE_W = WORD_W * LINE_WORDS;

    typedef struct packed {
        logic              rw;
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [OFF_W-1:0]  off;
        logic [WORD_W-1:0] din;
    } req_t;

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        replay_q, replay_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic              arr_valid, arr_dirty;
    logic [TAG_W-1:0]  arr_tag;
    logic [LINE_W-1:0] arr_line;
    logic              lookup_hit;
    logic              wr_en, fill_en;

    // Output copies, driven by the output process.
    logic              is_ready_o, is_output_valid_o, is_hit_o;
    logic [31:0]       dout_o;
    logic              mem_req_o, mem_req_write_o;
    logic [31:0]       mem_req_addr_o;
    logic [LINE_W-1:0] mem_req_data_o;

    // Byte-offset bits are never needed.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];

    cache_line_array #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk_i       (clk),
        .reset_i     (reset),
        .rd_idx_i    (req_q.idx),
        .rd_valid_o  (arr_valid),
        .rd_dirty_o  (arr_dirty),
        .rd_tag_o    (arr_tag),
        .rd_line_o   (arr_line),
        .wr_en_i     (wr_en),
        .wr_idx_i    (req_q.idx),
        .wr_off_i    (req_q.off),
        .wr_data_i   (req_q.din),
        .fill_en_i   (fill_en),
        .fill_idx_i  (req_q.idx),
        .fill_tag_i  (req_q.tag),
        .fill_line_i (bus.mem_resp_data)
    );

    assign lookup_hit = arr_valid && (arr_tag == req_q.tag);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request latch, replay flag and performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= '0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            req_q      <= req_d;
            replay_q   <= replay_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next state; also latches the request on accept and tracks whether the
    // current TAG_CHECK is the replay after a fill.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        replay_d = replay_q;
        case (state_q)
            IDLE: begin
                if (bus.is_input_valid) begin
                    req_d    = '{rw:  bus.mem_rw,
                                 tag: bus.addr[ADDR_W-1 -: TAG_W],
                                 idx: bus.addr[2+OFF_W +: IDX_W],
                                 off: bus.addr[2 +: OFF_W],
                                 din: bus.din};
                    replay_d = 1'b0;
                    state_d  = TAG_CHECK;
                end
            end
            TAG_CHECK: begin
                if (lookup_hit) begin
                    state_d = IDLE;
                end else begin
                    replay_d = 1'b1;
                    state_d  = (arr_valid && arr_dirty) ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: if (bus.mem_req_ready)  state_d = ALLOCATE;
            ALLOCATE:   if (bus.mem_req_ready)  state_d = FILL_WAIT;
            FILL_WAIT:  if (bus.mem_resp_valid) state_d = TAG_CHECK;
            default:    state_d = IDLE;
        endcase
    end

    // Counters step once per request, on its first lookup only, and saturate.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == TAG_CHECK && !replay_q) begin
            if (lookup_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Outputs and array write strobes decoded from the current state.
    always_comb begin
        is_ready_o        = 1'b0;
        is_output_valid_o = 1'b0;
        is_hit_o          = 1'b0;
        dout_o            = '0;
        mem_req_o         = 1'b0;
        mem_req_write_o   = 1'b0;
        mem_req_addr_o    = '0;
        mem_req_data_o    = '0;
        wr_en             = 1'b0;
        fill_en           = 1'b0;
        case (state_q)
            IDLE: is_ready_o = 1'b1;
            TAG_CHECK: begin
                if (lookup_hit) begin
                    is_output_valid_o = 1'b1;
                    is_hit_o          = !replay_q;
                    wr_en             = req_q.rw;
                    if (!req_q.rw) dout_o = arr_line[req_q.off*WORD_W +: WORD_W];
                end
            end
            WRITE_BACK: begin
                mem_req_o       = 1'b1;
                mem_req_write_o = 1'b1;
                mem_req_addr_o  = {arr_tag, req_q.idx, {(OFF_W+2){1'b0}}};
                mem_req_data_o  = arr_line;
            end
            ALLOCATE: begin
                mem_req_o      = 1'b1;
                mem_req_addr_o = {req_q.tag, req_q.idx, {(OFF_W+2){1'b0}}};
            end
            FILL_WAIT: fill_en = bus.mem_resp_valid;
            default: ;
        endcase
    end

    assign bus.is_ready        = is_ready_o;
    assign bus.is_output_valid = is_output_valid_o;
    assign bus.is_hit          = is_hit_o;
    assign bus.dout            = dout_o;
    assign bus.mem_req         = mem_req_o;
    assign bus.mem_req_write   = mem_req_write_o;
    assign bus.mem_req_addr    = mem_req_addr_o;
    assign bus.mem_req_data    = mem_req_data_o;
    assign bus.hit_count       = hit_cnt_q;
    assign bus.miss_count      = miss_cnt_q;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a line-level cache model plus a
// flat memory image.
module tb_data_cache;
    import cache_defs::*;

    localparam int NS = 16;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_cache_if #(.LINE_WORDS(LW)) bus ();
    data_cache #(.NUM_SETS(NS), .LINE_WORDS(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vecs = 0;
    int errs = 0;

    // Memory image (what the DRAM holds) and CPU-visible image.
    bit [31:0] backing [bit [31:0]];
    bit [31:0] shadow  [bit [31:0]];
    // Which line each set holds, and whether it differs from memory.
    bit        res_v   [NS];
    bit        res_d   [NS];
    bit [23:0] res_tag [NS];
    int unsigned m_hits, m_misses;

    // Memory agent controls and observations.
    bit         pend;
    bit [31:0]  pend_addr;
    int         pend_cnt;
    int         lat = 3;
    int         hold_cnt = 0;
    int         stall_seen = 0;
    bit         stray = 0;
    bit         rnd_rdy = 0;
    bit         noise = 0;
    bit         wb_seen;
    bit [31:0]  wb_addr;
    bit [127:0] wb_data;
    int         rd_cnt;
    int         pulses = 0;

    function automatic bit [31:0] init_w(input bit [31:0] a);
        return (~a) ^ 32'h3C3C_0000;
    endfunction

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        bit [31:0] k;
        k = {a[31:2], 2'b00};
        return backing.exists(k) ? backing[k] : init_w(k);
    endfunction

    function automatic bit [31:0] sh_rd(input bit [31:0] a);
        bit [31:0] k;
        k = {a[31:2], 2'b00};
        return shadow.exists(k) ? shadow[k] : init_w(k);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: memory agent bookkeeping for the edge, then new inputs.
    task automatic tick();
        bit         acc, accw, stalled, rst_pre;
        bit [31:0]  pa;
        bit [127:0] pd;
        acc     = bus.mem_req && bus.mem_req_ready;
        accw    = bus.mem_req_write;
        pa      = bus.mem_req_addr;
        pd      = bus.mem_req_data;
        stalled = bus.mem_req && !bus.mem_req_ready;
        rst_pre = reset;
        @(posedge clk);
        #1;
        if (rst_pre) begin
            pend = 0;
        end else if (acc) begin
            if (accw) begin
                wb_seen = 1; wb_addr = pa; wb_data = pd;
                for (int w = 0; w < LW; w++) backing[pa + 32'(4*w)] = pd[32*w +: 32];
            end else begin
                rd_cnt++; pend = 1; pend_addr = pa; pend_cnt = lat;
            end
        end
        if (stalled && !rst_pre && !reset) begin
            chk("req_held", bus.mem_req, 1'b1);
            chk("req_addr_held", bus.mem_req_addr, pa);
            chk("req_write_held", bus.mem_req_write, accw);
            chk("req_data_held", bus.mem_req_data, pd);
            chk("busy_not_ready", bus.is_ready, 1'b0);
        end
        if (bus.is_output_valid) pulses++;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        if (pend) begin
            if (pend_cnt == 0) begin
                bus.mem_resp_valid = 1'b1;
                for (int w = 0; w < LW; w++) bus.mem_resp_data[32*w +: 32] = mem_rd(pend_addr + 32'(4*w));
                pend = 0;
            end else begin
                pend_cnt--;
            end
        end
        if (hold_cnt > 0 && bus.mem_req) begin
            bus.mem_req_ready = 1'b0;
            hold_cnt--;
            stall_seen++;
            if (stray && !bus.mem_resp_valid) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = {4{32'hBAD0_BAD0}};
                stray = 0;
            end
        end else begin
            bus.mem_req_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (noise) begin
            bus.is_input_valid = 1'($urandom_range(0, 1));
            bus.addr   = $urandom;
            bus.din    = $urandom;
            bus.mem_rw = 1'($urandom_range(0, 1));
        end
    endtask

    // Full request: accept, wait for the response, compare with the model.
    task automatic access(input bit rw, input bit [31:0] a, input bit [31:0] d,
                          input string nm, output bit [31:0] g_dout, output bit g_hit);
        bit [31:0]  wa, va, ed;
        bit [3:0]   idx;
        bit [23:0]  tg;
        bit         eh, ewb;
        bit [127:0] vd;
        int         n;
        wa  = {a[31:2], 2'b00};
        idx = a[7:4];
        tg  = a[31:8];
        n = 0;
        while (!bus.is_ready && n < 100) begin tick(); n++; end
        if (!bus.is_ready) chk({nm, "_ready_timeout"}, 0, 1);
        eh  = res_v[idx] && (res_tag[idx] == tg);
        ewb = !eh && res_v[idx] && res_d[idx];
        va  = {res_tag[idx], idx, 4'h0};
        for (int w = 0; w < LW; w++) vd[32*w +: 32] = sh_rd(va + 32'(4*w));
        ed  = rw ? 32'h0 : sh_rd(wa);
        wb_seen = 0; rd_cnt = 0;
        bus.is_input_valid = 1'b1; bus.addr = a; bus.mem_rw = rw; bus.din = d;
        tick();
        bus.is_input_valid = 1'b0;
        noise = 1;
        n = 0;
        while (!bus.is_output_valid && n < 200) begin tick(); n++; end
        noise = 0;
        bus.is_input_valid = 1'b0;
        if (!bus.is_output_valid) chk({nm, "_resp_timeout"}, 0, 1);
        g_dout = bus.dout;
        g_hit  = bus.is_hit;
        chk({nm, "_dout"}, g_dout, ed);
        chk({nm, "_hit"}, g_hit, eh);
        if (eh) chk({nm, "_hit_latency"}, n, 0);
        chk({nm, "_wb_seen"}, wb_seen, ewb);
        if (ewb) begin
            chk({nm, "_wb_addr"}, wb_addr, va);
            chk({nm, "_wb_data"}, wb_data, vd);
        end
        chk({nm, "_fill_reads"}, rd_cnt, eh ? 0 : 1);
        if (eh) m_hits++;
        else begin
            m_misses++;
            res_v[idx] = 1; res_tag[idx] = tg; res_d[idx] = 0;
        end
        if (rw) begin shadow[wa] = d; res_d[idx] = 1; end
        tick();
        chk({nm, "_ready_after"}, bus.is_ready, 1'b1);
        chk({nm, "_hit_count"}, bus.hit_count, m_hits);
        chk({nm, "_miss_count"}, bus.miss_count, m_misses);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin res_v[i] = 0; res_d[i] = 0; res_tag[i] = '0; end
        m_hits = 0; m_misses = 0;
        shadow = backing;
    endtask

    typedef struct {
        bit        rw;
        bit [31:0] a;
        bit [31:0] d;
        bit [31:0] exp_dout;
        bit        exp_hit;
        bit        exp_wb;
        bit [31:0] exp_wb_addr;
    } vec_t;

    vec_t      tbl [9];
    bit [31:0] g_dout;
    bit        g_hit;
    int        n;
    int unsigned h0, p0;

    initial begin
        tbl[0] = '{0, 32'h100, 32'h0,         32'hAAAA_AAAA, 0, 0, 32'h0};
        tbl[1] = '{0, 32'h104, 32'h0,         32'hBBBB_BBBB, 1, 0, 32'h0};
        tbl[2] = '{1, 32'h108, 32'h0000_DEAD, 32'h0,         1, 0, 32'h0};
        tbl[3] = '{0, 32'h108, 32'h0,         32'h0000_DEAD, 1, 0, 32'h0};
        tbl[4] = '{1, 32'h000, 32'h1234_5678, 32'h0,         0, 1, 32'h100};
        tbl[5] = '{0, 32'h100, 32'h0,         32'hAAAA_AAAA, 0, 1, 32'h000};
        tbl[6] = '{0, 32'h108, 32'h0,         32'h0000_DEAD, 1, 0, 32'h0};
        tbl[7] = '{0, 32'h10C, 32'h0,         32'hDDDD_DDDD, 1, 0, 32'h0};
        tbl[8] = '{0, 32'h000, 32'h0,         32'h1234_5678, 0, 0, 32'h0};

        backing[32'h100] = 32'hAAAA_AAAA;
        backing[32'h104] = 32'hBBBB_BBBB;
        backing[32'h108] = 32'hCCCC_CCCC;
        backing[32'h10C] = 32'hDDDD_DDDD;

        reset = 1'b1;
        bus.is_input_valid = 1'b0; bus.addr = '0; bus.mem_rw = 1'b0; bus.din = '0;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        pend = 0;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_is_ready", bus.is_ready, 1'b1);
        chk("rst_out_valid", bus.is_output_valid, 1'b0);
        chk("rst_dout", bus.dout, 32'h0);
        chk("rst_is_hit", bus.is_hit, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_hit_count", bus.hit_count, 32'h0);
        chk("rst_miss_count", bus.miss_count, 32'h0);

        // Directed vectors, memory latency 3.
        lat = 3;
        for (int i = 0; i < 9; i++) begin
            access(tbl[i].rw, tbl[i].a, tbl[i].d, $sformatf("vec%0d", i), g_dout, g_hit);
            chk($sformatf("vec%0d_tbl_dout", i), g_dout, tbl[i].exp_dout);
            chk($sformatf("vec%0d_tbl_hit", i), g_hit, tbl[i].exp_hit);
            chk($sformatf("vec%0d_tbl_wb", i), wb_seen, tbl[i].exp_wb);
            if (tbl[i].exp_wb) chk($sformatf("vec%0d_tbl_wb_addr", i), wb_addr, tbl[i].exp_wb_addr);
        end

        // ALLOCATE held off for 5 cycles with a stray response in the window.
        stall_seen = 0; hold_cnt = 5; stray = 1;
        access(0, 32'h4058, 32'h0, "alloc_stall", g_dout, g_hit);
        chk("alloc_stall_cycles", stall_seen, 5);
        chk("alloc_stall_dout", g_dout, mem_rd(32'h4058));

        // Reset while waiting for the fill.
        lat = 20;
        bus.is_input_valid = 1'b1; bus.addr = 32'h2044; bus.mem_rw = 1'b0;
        tick();
        bus.is_input_valid = 1'b0;
        n = 0;
        while (!pend && n < 50) begin tick(); n++; end
        chk("fill_pending_seen", pend, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk("midrst_is_ready", bus.is_ready, 1'b1);
        chk("midrst_mem_req", bus.mem_req, 1'b0);
        chk("midrst_out_valid", bus.is_output_valid, 1'b0);
        chk("midrst_hit_count", bus.hit_count, 32'h0);
        chk("midrst_miss_count", bus.miss_count, 32'h0);
        lat = 2;
        access(0, 32'h2044, 32'h0, "reload_after_rst", g_dout, g_hit);
        chk("reload_after_rst_miss", g_hit, 1'b0);

        // Ten hits with idle gaps between requests.
        access(0, 32'h3000, 32'h0, "warm_3000", g_dout, g_hit);
        h0 = bus.hit_count;
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) tick();
            access(1'($urandom_range(0, 1)), 32'h3000 + 32'($urandom_range(0, 3) * 4),
                   $urandom, $sformatf("hit10_%0d", i), g_dout, g_hit);
        end
        chk("hit10_pulses", pulses - p0, 10);
        chk("hit10_hit_count", bus.hit_count, h0 + 10);

        // Randomized traffic over a few conflicting tags.
        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            bit [31:0] a;
            bit [23:0] tg;
            case ($urandom_range(0, 3))
                0: tg = 24'h000001;
                1: tg = 24'h000002;
                2: tg = 24'h00ABCD;
                default: tg = 24'hFFFFFF;
            endcase
            a   = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
            lat = $urandom_range(0, 4);
            access(1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", i), g_dout, g_hit);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage and a multi-cycle line-granular data memory. It accepts one word load/store at a time through a valid/ready handshake and answers hits one cycle after acceptance. On a miss it evicts a dirty victim, fills the line, and replays the lookup. The MEM stage stalls the pipeline while `is_ready` is low or a response is pending.

## Interface
- `NUM_SETS`, 16: number of lines; power of two.
- `LINE_WORDS`, 4: 32-bit words per line; power of two.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `is_input_valid` input 1: CPU request present.
- `addr` input 32: byte address; bits [1:0] ignored.
- `mem_rw` input 1: 0 = load, 1 = store.
- `din` input 32: store data.
- `is_ready` output 1: cache can accept a request (IDLE only).
- `is_output_valid` output 1: one-cycle pulse completing the request.
- `dout` output 32: load data, valid with `is_output_valid`; 0 for stores.
- `is_hit` output 1: original lookup hit; valid with `is_output_valid`.
- `mem_req` output 1: memory request.
- `mem_req_write` output 1: 1 = line write-back, 0 = line read.
- `mem_req_addr` output 32: line-aligned address.
- `mem_req_data` output 32*LINE_WORDS: write-back line.
- `mem_req_ready` input 1: memory accepts request this cycle.
- `mem_resp_valid` input 1: read line returning.
- `mem_resp_data` input 32*LINE_WORDS: fill data.
- `hit_count`, `miss_count` output 32 each: saturating performance counters.

## Operation
- Address split: word offset `addr[2+:log2 LINE_WORDS]`, index next `log2 NUM_SETS` bits, tag the remainder (24 bits at defaults).
- Per line: valid, dirty, tag, data. Request fields latched on acceptance (`is_input_valid && is_ready`); input changes while busy are ignored.
- FSM:
  - IDLE: `is_ready=1`. On accept, go to TAG_CHECK.
  - TAG_CHECK: compare. On a hit, pulse `is_output_valid`. A load drives `dout`. A store writes the word and sets dirty. Then go to IDLE. On a miss, go to WRITE_BACK if the victim is valid and dirty, otherwise ALLOCATE.
  - WRITE_BACK: `mem_req=1`, `mem_req_write=1`, victim tag/index address, line data. On `mem_req_ready`, go to ALLOCATE.
  - ALLOCATE: `mem_req=1`, `mem_req_write=0`, request line address. On `mem_req_ready`, go to FILL_WAIT.
  - FILL_WAIT: on `mem_resp_valid`, write the line with valid=1, dirty=0 and the new tag. Go to TAG_CHECK, where the replay hits.
- `is_hit` reports the first TAG_CHECK result of the request; the replay does not change it.
- `hit_count` and `miss_count` increment once per request at its first TAG_CHECK, saturating at 0xFFFFFFFF.
- `mem_resp_valid` outside FILL_WAIT is ignored. `mem_req` is held stable until `mem_req_ready`.

## Timing
- Reset values: every valid/dirty bit 0, state IDLE, `is_ready=1`, all other outputs and counters 0.
- Hit: accept at cycle T, `is_output_valid` at T+1. Next accept at T+2.
- Clean miss: T+1 miss, ALLOCATE from T+2, FILL_WAIT, replay TAG_CHECK on the cycle after `mem_resp_valid`, response there.
- Dirty miss adds WRITE_BACK ahead of ALLOCATE, one cycle minimum.
- Reset mid-operation: abort in the same edge, drop the outstanding fill, lose dirty data; the memory model must tolerate the abandoned request.
- Back-to-back accesses to the same line after a fill hit with no memory traffic.

## Structure
- Shared header/package `cache_defs`: state encodings (IDLE, TAG_CHECK, WRITE_BACK, ALLOCATE, FILL_WAIT), default geometry, field-width derivations.
- Sub-module `cache_line_array`: valid/dirty/tag/data storage with one combinational read port, one word-write port and one line-fill port, synchronous reset of valid/dirty.
- FSM, request latch and counters live in `data_cache`.

## Test plan
- Cold load 0x100, memory line {A,B,C,D}, response 3 cycles after request → `dout=A`, `is_hit=0`, `miss_count=1`. Second load 0x104 → `dout=B` at T+1, `is_hit=1`.
- Store 0xDEAD to 0x108 after fill → hit, no `mem_req`. Load 0x108 → 0xDEAD.
- Dirty conflict: store to 0x000, then load 0x100 at 16 sets × 16 B, so the same index → WRITE_BACK to 0x000 with the stored word, then fill 0x100.
- `mem_req_ready` held low 5 cycles in ALLOCATE → `mem_req` and `mem_req_addr` stable, `is_ready=0`. A stray `mem_resp_valid` during this window is ignored.
- Reset asserted in FILL_WAIT → next cycle IDLE, counters 0, reload of the same address misses.
- Drive 10 hits interleaved with `is_input_valid` toggling → exactly 10 `is_output_valid` pulses, `hit_count` exact.
